// File: rtl/mult_div_unit_if.sv
// ============================================================================
//  Module      : mult_div_unit_if
//  Description : Handshake/operand/result bundle between the multicycle
//                control/datapath (master) and mult_div_unit (slave).
//                  start    - one-cycle request pulse
//                  op[1:0]  - op[0]: 0 mult, 1 div; op[1]: 1 unsigned
//                  a, b     - operand A (register A), operand B (ALU B-mux)
//                  hi, lo   - HI/LO result registers
//                  busy     - operation in progress
//                  done     - one-cycle completion pulse
//                  div_zero - divide-by-zero flag
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mult_div_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    modport master (
        output start, op, a, b,
        input  hi, lo, busy, done, div_zero
    );

    modport slave (
        input  start, op, a, b,
        output hi, lo, busy, done, div_zero
    );
endinterface

`default_nettype wire

// File: rtl/mult_div_unit.sv
// ============================================================================
//  Module      : mult_div_unit
//  Description : Sequential 32-bit multiply/divide unit writing HI/LO.
//                Radix-2 Booth multiply and restoring divide on magnitudes,
//                one iteration per clock, 32 iterations per operation.
//  Ports       : clk      - clock, rising edge
//                reset_n  - asynchronous active-low reset
//                bus      - mult_div_unit_if.slave (start/op/a/b in,
//                           hi/lo/busy/done/div_zero out, all registered)
//  Config      : MULT_DIV_UNSIGNED_EN - when defined, op[1]=1 selects
//                multu/divu; otherwise op[1] is ignored (all signed).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_unit (
    input  wire logic       clk,
    input  wire logic       reset_n,
    mult_div_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MULT   = 2'd1,
        S_DIV    = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    localparam logic [5:0] c_LAST_ITER = 6'd31;

    state_t      r_state;
    logic [5:0]  r_cnt;
    // Mult: {upper[31:0], multiplier[31:0], guard}.
    // Div : {1'b0, remainder[31:0], dividend/quotient[31:0]}.
    logic [64:0] r_acc;
    logic [31:0] r_mcand;      // multiplicand (mult) or divisor magnitude (div)
    logic        r_is_div;
    logic        r_dz;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;
    logic        r_done;
    logic        r_div_zero;

    // ------------------------------------------------------------------
    // Operand preparation at accept time
    // ------------------------------------------------------------------
    logic        w_unsigned;
    logic        w_is_div;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;

`ifdef MULT_DIV_UNSIGNED_EN
    logic        r_unsigned;
    logic [31:0] r_mplier;     // multiplier copy for the unsigned HI correction
    assign w_unsigned = bus.op[1];
`else
    logic w_unused_op1;
    assign w_unsigned   = 1'b0;
    assign w_unused_op1 = bus.op[1];
`endif

    assign w_is_div = bus.op[0];
    assign w_a_neg  = ~w_unsigned & bus.a[31];
    assign w_b_neg  = ~w_unsigned & bus.b[31];
    assign w_a_mag  = w_a_neg ? (~bus.a + 32'd1) : bus.a;
    assign w_b_mag  = w_b_neg ? (~bus.b + 32'd1) : bus.b;

    // ------------------------------------------------------------------
    // Booth step: the upper half is summed at 33 bits so the shifted-in
    // sign stays correct even for 0x80000000 operands.
    // ------------------------------------------------------------------
    logic [32:0] w_booth_up;
    logic [32:0] w_mcand_x;
    logic [32:0] w_booth_sum;
    logic [64:0] w_booth_next;

    assign w_booth_up = {r_acc[64], r_acc[64:33]};
    assign w_mcand_x  = {r_mcand[31], r_mcand};

    always_comb begin
        w_booth_sum = w_booth_up;
        case (r_acc[1:0])
            2'b01:   w_booth_sum = w_booth_up + w_mcand_x;
            2'b10:   w_booth_sum = w_booth_up - w_mcand_x;
            default: w_booth_sum = w_booth_up;
        endcase
    end

    assign w_booth_next = {w_booth_sum, r_acc[32:1]};

    // ------------------------------------------------------------------
    // Restoring divide step: the remainder never exceeds the divisor, so
    // 32 bits hold it; the shifted trial needs 33 plus a borrow bit.
    // ------------------------------------------------------------------
    logic [32:0] w_rem_shift;
    logic [33:0] w_diff;
    logic [64:0] w_div_next;

    assign w_rem_shift = {r_acc[63:32], r_acc[31]};
    assign w_diff      = {1'b0, w_rem_shift} - {2'b00, r_mcand};
    assign w_div_next  = w_diff[33] ? {1'b0, w_rem_shift[31:0], r_acc[30:0], 1'b0}
                                    : {1'b0, w_diff[31:0],      r_acc[30:0], 1'b1};

    // ------------------------------------------------------------------
    // Result formatting in FINISH
    // ------------------------------------------------------------------
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;
    logic [31:0] w_mul_hi;

    assign w_quo_fix = r_neg_q ? (~r_acc[31:0]  + 32'd1) : r_acc[31:0];
    assign w_rem_fix = r_neg_r ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];

`ifdef MULT_DIV_UNSIGNED_EN
    // The Booth core always forms the signed product; the unsigned product
    // differs only in HI, by b when a[31] is set and by a when b[31] is set.
    assign w_mul_hi = r_unsigned
                    ? (r_acc[64:33] + (r_mcand[31]  ? r_mplier : 32'd0)
                                    + (r_mplier[31] ? r_mcand  : 32'd0))
                    : r_acc[64:33];
`else
    assign w_mul_hi = r_acc[64:33];
`endif

    // ------------------------------------------------------------------
    // Control FSM and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 6'd0;
            r_acc      <= 65'd0;
            r_mcand    <= 32'd0;
            r_is_div   <= 1'b0;
            r_dz       <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
`ifdef MULT_DIV_UNSIGNED_EN
            r_unsigned <= 1'b0;
            r_mplier   <= 32'd0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_cnt      <= 6'd0;
                        r_is_div   <= w_is_div;
                        r_dz       <= w_is_div & (bus.b == 32'd0);
                        r_neg_q    <= w_a_neg ^ w_b_neg;
                        r_neg_r    <= w_a_neg;
                        r_busy     <= 1'b1;
                        r_div_zero <= 1'b0;
`ifdef MULT_DIV_UNSIGNED_EN
                        r_unsigned <= w_unsigned;
                        r_mplier   <= bus.b;
`endif
                        if (w_is_div) begin
                            r_mcand <= w_b_mag;
                            r_acc   <= {33'd0, w_a_mag};
                            // A zero divisor still passes through DIV for one
                            // cycle so done lands two edges after start.
                            r_state <= S_DIV;
                        end else begin
                            r_mcand <= bus.a;
                            r_acc   <= {32'd0, bus.b, 1'b0};
                            r_state <= S_MULT;
                        end
                    end
                end

                S_MULT: begin
                    r_acc <= w_booth_next;
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == c_LAST_ITER) begin
                        r_state <= S_FINISH;
                    end
                end

                S_DIV: begin
                    if (r_dz) begin
                        r_state <= S_FINISH;
                    end else begin
                        r_acc <= w_div_next;
                        r_cnt <= r_cnt + 6'd1;
                        if (r_cnt == c_LAST_ITER) begin
                            r_state <= S_FINISH;
                        end
                    end
                end

                S_FINISH: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 6'd0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    if (r_dz) begin
                        r_div_zero <= 1'b1;
                    end else if (r_is_div) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end else begin
                        r_hi <= w_mul_hi;
                        r_lo <= r_acc[32:1];
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.div_zero = r_div_zero;

endmodule

`default_nettype wire
